// File: rtl/decode_unit_pkg.sv
// Shared decode definitions for the Risky decode stage: instruction field layout,
// opcode constants, FSM states and opcode-class helpers.
package decode_unit_pkg;

   localparam int unsigned INSTRUCTION_SIZE  = 16;
   localparam int unsigned REG_ADDR_SIZE_DEF = 3;
   localparam int unsigned DATA_SIZE_DEF     = 32;

   localparam int unsigned OPC_LSB  = 12;
   localparam int unsigned DEST_LSB = 9;
   localparam int unsigned SRC0_LSB = 6;
   localparam int unsigned SRC1_LSB = 3;
   localparam int unsigned IMM_LSB  = 0;
   localparam int unsigned IMM_SIZE = 8;

   localparam logic [3:0] OPC_NOP   = 4'h0;
   localparam logic [3:0] OPC_LOADC = 4'h8;
   localparam logic [3:0] OPC_LOAD  = 4'h9;
   localparam logic [3:0] OPC_STORE = 4'hA;
   localparam logic [3:0] OPC_JMP   = 4'hB;
   localparam logic [3:0] OPC_JMPZ  = 4'hC;
   localparam logic [3:0] OPC_HALT  = 4'hF;

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   function automatic logic is_alu(input logic [3:0] op);
      return (op >= 4'h1) && (op <= 4'h7);
   endfunction

   function automatic logic reads_src0(input logic [3:0] op);
      return is_alu(op) || (op == OPC_LOAD) || (op == OPC_STORE) || (op == OPC_JMPZ);
   endfunction

   function automatic logic reads_src1(input logic [3:0] op);
      return is_alu(op) || (op == OPC_STORE);
   endfunction

   function automatic logic writes_dest(input logic [3:0] op);
      return is_alu(op) || (op == OPC_LOADC) || (op == OPC_LOAD);
   endfunction

endpackage

// File: rtl/decode_unit_hazard_detect.sv
// Combinational RAW hazard detection for decode. With DECODE_FORWARD_EN only the
// load-use case stalls and writeback bypass selects are produced.
module hazard_detect
   import decode_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_SIZE = REG_ADDR_SIZE_DEF
) (
   input  logic [REG_ADDR_SIZE-1:0] src0,
   input  logic [REG_ADDR_SIZE-1:0] src1,
   input  logic                     rd0,
   input  logic                     rd1,
   input  logic [3:0]               opcode_out,
   input  logic [REG_ADDR_SIZE-1:0] dest_out,
   input  logic                     wb_en,
   input  logic [REG_ADDR_SIZE-1:0] wb_dest,
`ifdef DECODE_FORWARD_EN
   output logic                     fwd0,
   output logic                     fwd1,
`endif
   output logic                     stall
);

   logic hit_exec;
   logic hit_wb;

   assign hit_exec = (rd0 && (src0 == dest_out)) || (rd1 && (src1 == dest_out));
   assign hit_wb   = wb_en && ((rd0 && (src0 == wb_dest)) || (rd1 && (src1 == wb_dest)));

`ifdef DECODE_FORWARD_EN
   assign fwd0  = wb_en && (wb_dest == src0);
   assign fwd1  = wb_en && (wb_dest == src1);
   assign stall = (opcode_out == OPC_LOAD) && hit_exec;
`else
   // Without a bypass, the reg file still returns the pre-write value during writeback.
   assign stall = (writes_dest(opcode_out) && hit_exec) || hit_wb;
`endif

endmodule

// File: rtl/decode_unit.sv
// Decode stage: reg-file read, hazard stall, HALT FSM and execute pipeline register.
// Optional writeback bypass enabled by defining DECODE_FORWARD_EN.
module decode_unit
   import decode_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_SIZE = REG_ADDR_SIZE_DEF,
   parameter int unsigned DATA_SIZE     = DATA_SIZE_DEF
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [INSTRUCTION_SIZE-1:0] instruction,
   input  logic                        jump,
   output logic [REG_ADDR_SIZE-1:0]    rf_addr0,
   output logic [REG_ADDR_SIZE-1:0]    rf_addr1,
   input  logic [DATA_SIZE-1:0]        rf_data0,
   input  logic [DATA_SIZE-1:0]        rf_data1,
   input  logic                        wb_en,
   input  logic [REG_ADDR_SIZE-1:0]    wb_dest,
   input  logic [DATA_SIZE-1:0]        wb_data,
   output logic                        stall,
   output logic                        halt,
   output logic [3:0]                  opcode_out,
   output logic [REG_ADDR_SIZE-1:0]    dest_out,
   output logic [DATA_SIZE-1:0]        operand0_out,
   output logic [DATA_SIZE-1:0]        operand1_out
);

   logic [3:0]               op;
   logic [REG_ADDR_SIZE-1:0] dest;
   logic [IMM_SIZE-1:0]      imm;
   logic [DATA_SIZE-1:0]     opnd0, opnd1;
   logic                     hazard;
   state_t                   state, state_next;
   logic [3:0]               opcode_next;
   logic [REG_ADDR_SIZE-1:0] dest_next;
   logic [DATA_SIZE-1:0]     operand0_next, operand1_next;

   assign op       = instruction[OPC_LSB +: 4];
   assign dest     = instruction[DEST_LSB +: REG_ADDR_SIZE];
   assign imm      = instruction[IMM_LSB +: IMM_SIZE];
   assign rf_addr0 = instruction[SRC0_LSB +: REG_ADDR_SIZE];
   assign rf_addr1 = instruction[SRC1_LSB +: REG_ADDR_SIZE];

`ifdef DECODE_FORWARD_EN
   logic fwd0, fwd1;

   hazard_detect #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_hazard (
      .src0(rf_addr0), .src1(rf_addr1),
      .rd0(reads_src0(op)), .rd1(reads_src1(op)),
      .opcode_out(opcode_out), .dest_out(dest_out),
      .wb_en(wb_en), .wb_dest(wb_dest),
      .fwd0(fwd0), .fwd1(fwd1),
      .stall(hazard)
   );

   assign opnd0 = fwd0 ? wb_data : rf_data0;
   assign opnd1 = fwd1 ? wb_data : rf_data1;
`else
   logic wb_data_unused;

   hazard_detect #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_hazard (
      .src0(rf_addr0), .src1(rf_addr1),
      .rd0(reads_src0(op)), .rd1(reads_src1(op)),
      .opcode_out(opcode_out), .dest_out(dest_out),
      .wb_en(wb_en), .wb_dest(wb_dest),
      .stall(hazard)
   );

   assign opnd0          = rf_data0;
   assign opnd1          = rf_data1;
   assign wb_data_unused = ^wb_data;
`endif

   always_comb begin
      state_next    = state;
      opcode_next   = OPC_NOP;
      dest_next     = '0;
      operand0_next = '0;
      operand1_next = '0;
      stall         = 1'b0;
      // jump and HALTED both load a NOP and suppress the stall; a held bubble otherwise.
      if (state == ST_RUN && !jump) begin
         if (hazard) begin
            stall = !reset;
         end else begin
            case (op)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                  opcode_next   = op;
                  dest_next     = dest;
                  operand0_next = opnd0;
                  operand1_next = opnd1;
               end
               OPC_LOADC: begin
                  opcode_next   = op;
                  dest_next     = dest;
                  operand1_next = {{(DATA_SIZE-IMM_SIZE){1'b0}}, imm};
               end
               OPC_LOAD: begin
                  opcode_next   = op;
                  dest_next     = dest;
                  operand0_next = opnd0;
               end
               OPC_STORE: begin
                  opcode_next   = op;
                  operand0_next = opnd0;
                  operand1_next = opnd1;
               end
               OPC_JMP: begin
                  opcode_next   = op;
                  operand1_next = {{(DATA_SIZE-IMM_SIZE){1'b0}}, imm};
               end
               OPC_JMPZ: begin
                  opcode_next   = op;
                  operand0_next = opnd0;
               end
               OPC_HALT: state_next = ST_HALTED;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_RUN;
         opcode_out   <= OPC_NOP;
         dest_out     <= '0;
         operand0_out <= '0;
         operand1_out <= '0;
      end else begin
         state        <= state_next;
         opcode_out   <= opcode_next;
         dest_out     <= dest_next;
         operand0_out <= operand0_next;
         operand1_out <= operand1_next;
      end
   end

   assign halt = (state == ST_HALTED);

endmodule
